// File: rtl/mul_acc_pipe_if.sv
// Beat-in / partial-sum-out bundle for mul_acc_pipe. The master side drives the beats and out_ready.
// The slave side is the MAC unit.
interface mul_acc_pipe_if #(
    parameter int PSUM_W = 32,
    parameter int A_W    = 8,
    parameter int B_W    = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [A_W-1:0]    in_a;
    logic [B_W-1:0]    in_b;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [PSUM_W-1:0] out_psum;
    logic              out_mode;
    logic              out_ovf;

    modport master (
        output in_valid, in_mode, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_psum, out_mode, out_ovf
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_psum, out_mode, out_ovf
    );
endinterface

// File: rtl/mul_acc_pipe.sv
// Two-stage MAC that works as one 8x8 unit or as two 4x8 lanes, and emits one psum per in_last-delimited group.
// A result appears two cycles after its last beat. The whole pipe stalls while a result is held (in_ready = !out_valid | out_ready).
module mul_acc_pipe #(
    parameter int PSUM_W = 32,
    parameter int A_W    = 8,
    parameter int B_W    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_acc_pipe_if.slave bus
);
    localparam int LW   = PSUM_W / 2;
    localparam int PP_W = 4 + B_W;
    localparam int PR_W = A_W + B_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_grp_mode;

    logic              r_v1;
    logic [PP_W-1:0]   r_pp_hi;
    logic [PP_W-1:0]   r_pp_lo;
    logic              r_last1;
    logic              r_first1;
    logic              r_mode1;

    logic [PSUM_W-1:0] r_acc;
    logic              r_ovf_acc;
    logic              r_out_valid;
    logic [PSUM_W-1:0] r_out_psum;
    logic              r_out_mode;
    logic              r_out_ovf;

    logic              w_adv;
    logic              w_accept;
    logic              w_first;
    logic [PR_W-1:0]   w_prod;
    logic [PSUM_W-1:0] w_base;
    logic [PSUM_W:0]   w_sum_full;
    logic [LW:0]       w_sum_hi;
    logic [LW:0]       w_sum_lo;
    logic [PSUM_W-1:0] w_sum;
    logic              w_ovf;
    logic              w_ovf_grp;

    assign w_adv    = !r_out_valid || bus.out_ready;
    assign w_accept = bus.in_valid && w_adv;
    assign w_first  = (r_state == ST_IDLE);

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_out_valid;
    assign bus.out_psum  = r_out_psum;
    assign bus.out_mode  = r_out_mode;
    assign bus.out_ovf   = r_out_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grp_mode <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && w_first) begin
                r_grp_mode <= bus.in_mode;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && !bus.in_last) w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (w_accept && bus.in_last)  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // S1: split a into nibbles so both modes share the same two partial products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_pp_hi  <= '0;
            r_pp_lo  <= '0;
            r_last1  <= 1'b0;
            r_first1 <= 1'b0;
            r_mode1  <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_pp_hi  <= {{B_W{1'b0}}, bus.in_a[7:4]} * {4'b0000, bus.in_b};
                r_pp_lo  <= {{B_W{1'b0}}, bus.in_a[3:0]} * {4'b0000, bus.in_b};
                r_last1  <= bus.in_last;
                r_first1 <= w_first;
                r_mode1  <= w_first ? bus.in_mode : r_grp_mode;
            end
        end
    end

    always_comb begin
        w_prod     = {r_pp_hi, 4'b0000} + {4'b0000, r_pp_lo};
        w_base     = r_first1 ? '0 : r_acc;
        w_sum_full = {1'b0, w_base} + {1'b0, PSUM_W'(w_prod)};
        // Lanes are added separately so a lo-lane carry never leaks into the hi lane
        w_sum_lo   = {1'b0, w_base[LW-1:0]}      + {1'b0, LW'(r_pp_lo)};
        w_sum_hi   = {1'b0, w_base[PSUM_W-1:LW]} + {1'b0, LW'(r_pp_hi)};
        if (r_mode1) begin
            w_sum = {w_sum_hi[LW-1:0], w_sum_lo[LW-1:0]};
            w_ovf = w_sum_hi[LW] || w_sum_lo[LW];
        end else begin
            w_sum = w_sum_full[PSUM_W-1:0];
            w_ovf = w_sum_full[PSUM_W];
        end
        w_ovf_grp = (!r_first1 && r_ovf_acc) || w_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_ovf_acc   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_psum  <= '0;
            r_out_mode  <= 1'b0;
            r_out_ovf   <= 1'b0;
        end else if (w_adv) begin
            if (r_v1 && r_last1) begin
                r_out_valid <= 1'b1;
                r_out_psum  <= w_sum;
                r_out_ovf   <= w_ovf_grp;
                r_out_mode  <= r_mode1;
                r_acc       <= '0;
                r_ovf_acc   <= 1'b0;
            end else begin
                r_out_valid <= 1'b0;
                if (r_v1) begin
                    r_acc     <= w_sum;
                    r_ovf_acc <= w_ovf_grp;
                end
            end
        end
    end
endmodule

// File: tb/tb_mul_acc_pipe.sv
// Bench for mul_acc_pipe: directed cases plus random groups, checked against an arithmetic group model.
module tb_mul_acc_pipe;
    localparam int    PSUM_W = 32;
    localparam int    LW     = PSUM_W / 2;
    localparam longint WMOD  = longint'(1) << PSUM_W;
    localparam longint LMOD  = longint'(1) << LW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_acc_pipe_if #(.PSUM_W(PSUM_W)) bus();

    mul_acc_pipe #(.PSUM_W(PSUM_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        longint psum;
        bit     mode;
        bit     ovf;
    } exp_t;

    exp_t   q[$];
    bit     g_open = 1'b0;
    bit     g_mode = 1'b0;
    longint g_s0, g_hi, g_lo;

    // Group model: keep exact unbounded sums and reduce only when the group closes
    task automatic model_beat(input bit mode, input int a, input int b, input bit last);
        exp_t e;
        if (!g_open) begin
            g_open = 1'b1;
            g_mode = mode;
            g_s0 = 0; g_hi = 0; g_lo = 0;
        end
        g_s0 += longint'(a * b);
        g_hi += longint'((a / 16) * b);
        g_lo += longint'((a % 16) * b);
        if (last) begin
            if (g_mode) begin
                e.psum = ((g_hi % LMOD) * LMOD) + (g_lo % LMOD);
                e.ovf  = (g_hi >= LMOD) || (g_lo >= LMOD);
            end else begin
                e.psum = g_s0 % WMOD;
                e.ovf  = (g_s0 >= WMOD);
            end
            e.mode = g_mode;
            q.push_back(e);
            g_open = 1'b0;
        end
    endtask

    bit     o_rdy = 1'b1;
    bit     rand_rdy = 1'b0;
    longint last_psum = 0;
    bit     last_mode = 1'b0;
    bit     last_ovf = 1'b0;

    task automatic step(input bit v, input bit m, input int a, input int b, input bit l, output bit fired);
        exp_t e;
        @(negedge clk);
        if (rand_rdy) o_rdy = ($urandom_range(0, 3) != 0);
        bus.in_valid  = v;
        bus.in_mode   = m;
        bus.in_a      = a[7:0];
        bus.in_b      = b[7:0];
        bus.in_last   = l;
        bus.out_ready = o_rdy;
        #1;
        fired = v && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            last_psum = longint'(bus.out_psum);
            last_mode = bus.out_mode;
            last_ovf  = bus.out_ovf;
            if (q.size() == 0) begin
                chk("out_expected", 64'(q.size()), 64'd1);
            end else begin
                e = q.pop_front();
                chk("sb_psum", 64'(bus.out_psum), 64'(e.psum));
                chk("sb_mode", 64'(bus.out_mode), 64'(e.mode));
                chk("sb_ovf",  64'(bus.out_ovf),  64'(e.ovf));
            end
        end
        if (fired) model_beat(m, a, b, l);
    endtask

    task automatic send(input bit m, input int a, input int b, input bit l);
        bit f;
        int k;
        k = 0;
        do begin
            step(1'b1, m, a, b, l, f);
            k++;
        end while (!f && k < 200);
        chk("send_accepted", 64'(f), 64'd1);
    endtask

    task automatic idle(input int n);
        bit f;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, f);
    endtask

    task automatic flush();
        bit f;
        int k;
        k = 0;
        while ((q.size() != 0 || bus.out_valid) && k < 100) begin
            step(1'b0, 1'b0, 0, 0, 1'b0, f);
            k++;
        end
        chk("flush_done", 64'(q.size()), 64'd0);
    endtask

    initial begin
        bit f;
        int len;
        bit gm;

        bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.in_last = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_psum",  64'(bus.out_psum),  64'd0);
        chk("rst_out_mode",  64'(bus.out_mode),  64'd0);
        chk("rst_out_ovf",   64'(bus.out_ovf),   64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // 8x8 single beat and its latency
        send(1'b0, 'hFF, 'hFF, 1'b1);
        step(1'b0, 1'b0, 0, 0, 1'b0, f);
        chk("t1_not_yet", 64'(bus.out_valid), 64'd0);
        step(1'b0, 1'b0, 0, 0, 1'b0, f);
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_psum", 64'(last_psum), 64'hFE01);
        chk("t1_mode", 64'(last_mode), 64'd0);
        chk("t1_ovf",  64'(last_ovf),  64'd0);

        send(1'b1, 'h21, 'h10, 1'b1);
        flush();
        chk("t2_psum", 64'(last_psum), 64'h0020_0010);
        chk("t2_mode", 64'(last_mode), 64'd1);

        send(1'b0, 10, 10, 1'b0);
        idle(1);
        send(1'b0, 10, 10, 1'b0);
        send(1'b0, 10, 10, 1'b1);
        flush();
        chk("t3_psum", 64'(last_psum), 64'd300);

        for (int i = 0; i < 18; i++) send(1'b1, 'h0F, 'hFF, (i == 17));
        flush();
        chk("t4_psum", 64'(last_psum), 64'd3314);
        chk("t4_ovf",  64'(last_ovf),  64'd1);
        send(1'b1, 'h11, 1, 1'b1);
        flush();
        chk("t4b_psum", 64'(last_psum), 64'h0001_0001);
        chk("t4b_ovf",  64'(last_ovf),  64'd0);

        // Held result stalls the input side without losing beats
        o_rdy = 1'b0;
        send(1'b0, 3, 4, 1'b1);
        send(1'b0, 5, 6, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 7, 8, 1'b1, f);
            chk("t5_no_accept", 64'(f), 64'd0);
            chk("t5_in_ready",  64'(bus.in_ready),  64'd0);
            chk("t5_valid",     64'(bus.out_valid), 64'd1);
            chk("t5_hold_psum", 64'(bus.out_psum),  64'd12);
        end
        o_rdy = 1'b1;
        send(1'b0, 7, 8, 1'b1);
        flush();
        chk("t5_last", 64'(last_psum), 64'd56);

        // Reset in the middle of a group
        send(1'b0, 5, 5, 1'b0);
        send(1'b0, 5, 5, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        g_open = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_psum",  64'(bus.out_psum),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 1, 1, 1'b1);
        flush();
        chk("t6_psum", 64'(last_psum), 64'd1);

        send(1'b0, 3, 3, 1'b0);
        send(1'b1, 'h12, 2, 1'b1);
        flush();
        chk("t6_mode_kept", 64'(last_mode), 64'd0);
        chk("t6_mode_psum", 64'(last_psum), 64'd45);

        // Random groups with bubbles, random backpressure and ignored mid-group mode flips
        rand_rdy = 1'b1;
        for (int g = 0; g < 200; g++) begin
            len = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(1, 6));
            gm  = bit'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send((i == 0) ? gm : bit'($urandom_range(0, 1)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), (i == len - 1));
            end
        end
        rand_rdy = 1'b0;
        o_rdy = 1'b1;
        flush();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
